gate8_checker: RTL

GATE8_CHECKER -- requirements
Module: gate8_checker

---
 rtl/gate8_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gate8_checker.sv
// gate8_checker: scores an 8-bit two-input gate DUT against OR/AND/XOR/NOR of its
// operands, aligning expected values to the DUT latency and capturing the first failure.
module gate8_checker #(
   parameter int N_VEC = 16,
   parameter int DELAY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op_sel,
   input  logic       valid,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       mismatch,
   output logic [7:0] vec_count,
   output logic [7:0] err_count,
   output logic [7:0] first_idx,
   output logic [7:0] first_exp,
   output logic [7:0] first_got
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0] OP_OR   = 2'b00;
   localparam logic [1:0] OP_AND  = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [7:0] LAST_IDX = 8'(N_VEC - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] op_r;
   logic       first_seen;
   logic       launch;
   logic       vld_p0;
   logic [7:0] exp_p0;
   logic       vld_d;
   logic [7:0] exp_d;
   logic       cmp;
   logic       fail;

   function automatic logic [7:0] gate_eval(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
      case (op)
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_XOR:  return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A start is only honoured outside RUN; it also flushes the alignment pipeline.
   assign launch = start && (state != RUN);

   // Stage p0: vector enters the pipeline only while a run is active.
   assign vld_p0 = valid && (state == RUN);
   assign exp_p0 = gate_eval(op_r, in1, in2);

   generate
      if (DELAY == 0) begin : g_direct
         assign vld_d = vld_p0;
         assign exp_d = exp_p0;
      end else begin : g_pipe
         logic       vld_p [1:DELAY];
         logic [7:0] exp_p [1:DELAY];

         // Stages p1..pDELAY: valid is control and gets reset/flushed, expected data is not.
         always_ff @(posedge clk) begin
            if (rst || launch) begin
               for (int i = 1; i <= DELAY; i++) vld_p[i] <= 1'b0;
            end else begin
               vld_p[1] <= vld_p0;
               for (int i = 2; i <= DELAY; i++) vld_p[i] <= vld_p[i-1];
            end
         end

         always_ff @(posedge clk) begin
            exp_p[1] <= exp_p0;
            for (int i = 2; i <= DELAY; i++) exp_p[i] <= exp_p[i-1];
         end

         assign vld_d = vld_p[DELAY];
         assign exp_d = exp_p[DELAY];
      end
   endgenerate

   // Compare stage: aligned expected value against the live DUT output.
   assign cmp  = vld_d && (state == RUN);
   assign fail = cmp && (dut_out != exp_d);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cmp && (vec_count == LAST_IDX)) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // Result stage: counters and first-failure capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r       <= 2'b00;
         mismatch   <= 1'b0;
         vec_count  <= 8'd0;
         err_count  <= 8'd0;
         first_seen <= 1'b0;
         first_idx  <= 8'd0;
         first_exp  <= 8'd0;
         first_got  <= 8'd0;
      end else begin
         mismatch <= fail;
         if (launch) begin
            op_r       <= op_sel;
            vec_count  <= 8'd0;
            err_count  <= 8'd0;
            first_seen <= 1'b0;
            first_idx  <= 8'd0;
            first_exp  <= 8'd0;
            first_got  <= 8'd0;
         end else if (cmp) begin
            vec_count <= vec_count + 8'd1;
            if (fail) begin
               err_count <= sat_inc(err_count);
               if (!first_seen) begin
                  first_seen <= 1'b1;
                  first_idx  <= vec_count;
                  first_exp  <= exp_d;
                  first_got  <= dut_out;
               end
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = (state == DONE) && (err_count == 8'd0);

endmodule
